// File: rtl/m_store_buffer_if.sv
// m_store_buffer_if: request and memory-drain signals of the M-stage store buffer.
//   req_*  : store request from the pipeline (valid/ready, size, address, right-aligned data)
//            plus the registered misalignment drop pulse.
//   mem_*  : head entry of the buffer towards the data memory (valid/ready, aligned
//            address, byte enables, lane-placed data).
// Modports: master = pipeline/memory model side, slave = store buffer side.
interface m_store_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_misalign;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_byteen;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output req_valid, req_size, req_addr, req_data, mem_ready,
    input  req_ready, req_misalign, mem_valid, mem_addr, mem_byteen, mem_wdata
  );

  modport slave (
    input  req_valid, req_size, req_addr, req_data, mem_ready,
    output req_ready, req_misalign, mem_valid, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/m_store_buffer.sv
// m_store_buffer: M-stage store path. Checks alignment of byte/half/word/dword stores,
// builds lane-placed write data with byte enables and queues accepted stores in a
// DEPTH-entry circular FIFO drained to data memory over a valid/ready port.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-low reset
//   bus    : m_store_buffer_if.slave (req_* request side, mem_* drain side)
//   count  : number of occupied entries
// Optional feature: define STORE_MERGE_EN to merge a store into the tail entry when
// it targets the same aligned word and the tail is not the head.
module m_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  m_store_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Right-aligned lane mask for a size code (1, 2, 4 or 8 bytes).
  function automatic logic [NB-1:0] f_lane_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      2'd3:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m[NB-1:0];
  endfunction

  // Expand byte enables to a per-bit mask.
  function automatic logic [DATA_W-1:0] f_bit_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Offset not a multiple of the access size, or access wider than the bus.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [OB-1:0] off);
    logic [3:0] o;
    o = 4'(off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return o[0];
      2'd2:    return |o[1:0];
      2'd3:    return (NB != 8) || (|o[2:0]);
      default: return 1'b1;
    endcase
  endfunction

  logic [ADDR_W-1:0] addr_q_r [DEPTH];
  logic [NB-1:0]     be_q_r   [DEPTH];
  logic [DATA_W-1:0] data_q_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              misalign_r;

  logic [OB-1:0]     off_s;
  logic [ADDR_W-1:0] base_addr_s;
  logic [NB-1:0]     lane_s, be_s;
  logic [DATA_W-1:0] wdata_s;
  logic              mis_s, full_s, empty_s, merge_hit_s, ready_s;
  logic              hs_s, push_s, merge_s, pop_s;
  logic [PW-1:0]     tail_s;

  assign off_s       = bus.req_addr[OB-1:0];
  assign base_addr_s = {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
  assign lane_s      = f_lane_mask(bus.req_size);
  assign be_s        = lane_s << off_s;
  assign wdata_s     = (bus.req_data & f_bit_mask(lane_s)) << {off_s, 3'b000};
  assign mis_s       = f_misaligned(bus.req_size, off_s);
  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == {CW{1'b0}});
  assign tail_s      = wr_ptr_r - PW'(1'b1);

  // Tail-merge detection; head is excluded by requiring at least two entries.
  always_comb begin
`ifdef STORE_MERGE_EN
    if ((count_r >= CW'(2)) && !mis_s && (addr_q_r[tail_s] == base_addr_s)) begin
      merge_hit_s = 1'b1;
    end else begin
      merge_hit_s = 1'b0;
    end
`else
    merge_hit_s = 1'b0;
`endif
  end

  // A full buffer only accepts a merging store; pops do not free space this cycle.
  assign ready_s = !full_s || merge_hit_s;
  assign hs_s    = bus.req_valid && ready_s;
  assign push_s  = hs_s && !mis_s && !merge_hit_s;
  assign merge_s = hs_s && !mis_s && merge_hit_s;
  assign pop_s   = !empty_s && bus.mem_ready;

  // Pointer, occupancy and misalignment-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= hs_s && mis_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: push writes at the write pointer, merge updates the tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q_r[i] <= {ADDR_W{1'b0}};
        be_q_r[i]   <= {NB{1'b0}};
        data_q_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      addr_q_r[wr_ptr_r] <= base_addr_s;
      be_q_r[wr_ptr_r]   <= be_s;
      data_q_r[wr_ptr_r] <= wdata_s;
    end else if (merge_s) begin
      be_q_r[tail_s]   <= be_q_r[tail_s] | be_s;
      data_q_r[tail_s] <= (data_q_r[tail_s] & ~f_bit_mask(be_s)) | wdata_s;
    end
  end

  // Head presentation; zeros when nothing is queued.
  always_comb begin
    if (empty_s) begin
      bus.mem_addr   = {ADDR_W{1'b0}};
      bus.mem_byteen = {NB{1'b0}};
      bus.mem_wdata  = {DATA_W{1'b0}};
    end else begin
      bus.mem_addr   = addr_q_r[rd_ptr_r];
      bus.mem_byteen = be_q_r[rd_ptr_r];
      bus.mem_wdata  = data_q_r[rd_ptr_r];
    end
  end

  assign bus.mem_valid    = !empty_s;
  assign bus.req_ready    = ready_s;
  assign bus.req_misalign = misalign_r;
  assign count            = count_r;
endmodule

// File: tb/tb_m_store_buffer.sv
// tb_m_store_buffer: scoreboard bench for m_store_buffer (32-bit instance with a
// per-cycle reference model, plus a 64-bit instance for doubleword lane placement).
module tb_m_store_buffer;
`ifdef STORE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] count32, count64;
  int n_checks = 0;
  int n_pass = 0;
  ent_t sb_q[$];
  logic mis_exp = 1'b0;

  m_store_buffer_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  m_store_buffer_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

  m_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .reset(reset), .bus(bus32), .count(count32));
  m_store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .bus(bus64), .count(count64));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference lane placement, byte by byte.
  function automatic void f_model(input logic [1:0] size, input logic [31:0] addr,
                                  input logic [31:0] data, output logic [3:0] be,
                                  output logic [31:0] wd, output logic mis);
    int sz = 1 << size;
    int off = int'(addr[1:0]);
    be = 4'h0;
    wd = 32'h0;
    mis = ((off % sz) != 0) || (sz > 4);
    if (!mis) begin
      for (int b = 0; b < sz; b++) begin
        be[off+b] = 1'b1;
        wd[(off+b)*8 +: 8] = data[b*8 +: 8];
      end
    end
  endfunction

  // Scoreboard monitor for the 32-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    logic [3:0] be_m;
    logic [31:0] wd_m;
    logic mis_m, hit_m, rdy_m, hs_m;
    ent_t t;
    if (!reset) begin
      sb_q.delete();
      mis_exp = 1'b0;
    end else begin
      f_model(bus32.req_size, bus32.req_addr, bus32.req_data, be_m, wd_m, mis_m);
      hit_m = 1'b0;
      if (MERGE && !mis_m && sb_q.size() >= 2)
        hit_m = (sb_q[sb_q.size()-1].addr == {bus32.req_addr[31:2], 2'b00});
      rdy_m = (sb_q.size() < 4) || hit_m;
      check_eq("count", 64'(count32), 64'(sb_q.size()));
      check_eq("mem_valid", 64'(bus32.mem_valid), 64'(sb_q.size() != 0));
      check_eq("req_misalign", 64'(bus32.req_misalign), 64'(mis_exp));
      check_eq("req_ready", 64'(bus32.req_ready), 64'(rdy_m));
      if (sb_q.size() == 0) begin
        check_eq("idle_bus", {bus32.mem_addr, bus32.mem_wdata} | 64'(bus32.mem_byteen), 64'h0);
      end else begin
        check_eq("head", {bus32.mem_addr, bus32.mem_wdata}, {sb_q[0].addr, sb_q[0].data});
        check_eq("head_be", 64'(bus32.mem_byteen), 64'(sb_q[0].be));
      end
      hs_m = bus32.req_valid && rdy_m;
      if (sb_q.size() != 0 && bus32.mem_ready) void'(sb_q.pop_front());
      mis_exp = hs_m && mis_m;
      if (hs_m && !mis_m) begin
        if (hit_m) begin
          t = sb_q[sb_q.size()-1];
          for (int b = 0; b < 4; b++) if (be_m[b]) t.data[b*8 +: 8] = wd_m[b*8 +: 8];
          t.be = t.be | be_m;
          sb_q[sb_q.size()-1] = t;
        end else begin
          t.addr = {bus32.req_addr[31:2], 2'b00};
          t.be = be_m;
          t.data = wd_m;
          sb_q.push_back(t);
        end
      end
    end
  end

  // Present one request and hold it until accepted (bounded).
  task automatic send32(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    bit done = 1'b0;
    bus32.req_valid = 1'b1;
    bus32.req_size = size;
    bus32.req_addr = addr;
    bus32.req_data = data;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus32.req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("send_timeout", 64'd0, 64'd1);
    bus32.req_valid = 1'b0;
  endtask

  task automatic wait_empty32();
    bit done = 1'b0;
    bus32.mem_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!bus32.mem_valid) done = 1'b1;
    end
    if (!done) check_eq("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    bus32.req_valid = 1'b0; bus32.req_size = 2'd0; bus32.req_addr = 32'h0;
    bus32.req_data = 32'h0; bus32.mem_ready = 1'b0;
    bus64.req_valid = 1'b0; bus64.req_size = 2'd0; bus64.req_addr = 32'h0;
    bus64.req_data = 64'h0; bus64.mem_ready = 1'b0;
    #2;
    check_eq("rst_count", 64'(count32), 64'd0);
    check_eq("rst_valid", 64'(bus32.mem_valid), 64'd0);
    check_eq("rst_ready", 64'(bus32.req_ready), 64'd1);
    check_eq("rst_misalign", 64'(bus32.req_misalign), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;

    // 64-bit instance: doubleword and upper-word lane placement.
    @(posedge clk); #1;
    bus64.req_valid = 1'b1; bus64.req_size = 2'd3; bus64.req_addr = 32'h8;
    bus64.req_data = 64'h1122334455667788;
    @(posedge clk); #1;
    bus64.req_valid = 1'b0;
    check_eq("d64_valid", 64'(bus64.mem_valid), 64'd1);
    check_eq("d64_addr", 64'(bus64.mem_addr), 64'h8);
    check_eq("d64_be", 64'(bus64.mem_byteen), 64'hFF);
    check_eq("d64_data", bus64.mem_wdata, 64'h1122334455667788);
    bus64.mem_ready = 1'b1;
    bus64.req_valid = 1'b1; bus64.req_size = 2'd2; bus64.req_addr = 32'hC;
    bus64.req_data = 64'h00000000AABBCCDD;
    @(posedge clk); #1;
    bus64.req_valid = 1'b0; bus64.mem_ready = 1'b0;
    check_eq("w64_count", 64'(count64), 64'd1);
    check_eq("w64_addr", 64'(bus64.mem_addr), 64'h8);
    check_eq("w64_be", 64'(bus64.mem_byteen), 64'hF0);
    check_eq("w64_data", bus64.mem_wdata, 64'hAABBCCDD00000000);

    // Byte store, one-cycle latency to the memory port.
    bus32.mem_ready = 1'b1;
    send32(2'd0, 32'h1003, 32'h000000AB);
    check_eq("sb_addr", 64'(bus32.mem_addr), 64'h1000);
    check_eq("sb_be", 64'(bus32.mem_byteen), 64'h8);
    check_eq("sb_data", 64'(bus32.mem_wdata), 64'hAB000000);
    // Misaligned half and illegal dword: consumed and dropped.
    send32(2'd1, 32'h2001, 32'h0000BEEF);
    check_eq("sh_mis", 64'(bus32.req_misalign), 64'd1);
    check_eq("sh_count", 64'(count32), 64'd0);
    send32(2'd3, 32'h3000, 32'h12345678);
    check_eq("sd32_mis", 64'(bus32.req_misalign), 64'd1);
    send32(2'd1, 32'h2002, 32'h0000BEEF);
    wait_empty32();

    // Fill with the memory stalled, then drain while more requests stream in.
    bus32.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send32(2'd2, 32'h10 + 32'(i*4), 32'hA0A0_0000 + 32'(i));
    check_eq("full_count", 64'(count32), 64'd4);
    check_eq("full_ready", 64'(bus32.req_ready), 64'd0);
    bus32.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) send32(2'd2, 32'h40 + 32'(i*4), 32'hB0B0_0000 + 32'(i));
    for (int i = 0; i < 6; i++) send32(2'(i % 3), 32'h80 + 32'(i*2), $urandom);
    wait_empty32();

    // Same-word stores: merge into the tail only when enabled.
    bus32.mem_ready = 1'b0;
    send32(2'd2, 32'h0, 32'hDEADBEEF);
    send32(2'd0, 32'h4, 32'h00000011);
    send32(2'd0, 32'h5, 32'h00000022);
    check_eq("merge_count", 64'(count32), MERGE ? 64'd2 : 64'd3);
    wait_empty32();

    // Asynchronous reset with three entries pending.
    bus32.mem_ready = 1'b0;
    send32(2'd2, 32'h100, 32'h1);
    send32(2'd2, 32'h200, 32'h2);
    send32(2'd2, 32'h300, 32'h3);
    check_eq("pre_rst_count", 64'(count32), 64'd3);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_count", 64'(count32), 64'd0);
    check_eq("async_rst_valid", 64'(bus32.mem_valid), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    bus32.mem_ready = 1'b1;
    send32(2'd1, 32'h42, 32'h0000CAFE);
    check_eq("post_rst_be", 64'(bus32.mem_byteen), 64'hC);
    check_eq("post_rst_data", 64'(bus32.mem_wdata), 64'hCAFE0000);
    wait_empty32();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
